// File: rtl/life_mem_pkg.sv
// Shared defaults and FSM encoding for the row-oriented BRAM master.
package life_mem_pkg;

   localparam int unsigned ADDR_W_DEF    = 10;
   localparam int unsigned DATA_W_DEF    = 128;
   localparam int unsigned RSP_DEPTH_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; count exposed for credit.
module rsp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clka,
   input  logic                         rst_n,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [WIDTH-1:0]             out_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   assign in_ready_o  = (count_q != FULL);
   assign out_valid_o = (count_q != '0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign count_o     = count_q;

   assign push = in_valid_i && in_ready_o;
   assign pop  = out_valid_o && out_ready_i;

   assign wr_ptr_d = push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
   assign rd_ptr_d = pop  ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
   assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only observable while count_q covers them.
   always_ff @(posedge clka) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

endmodule

// File: rtl/mem_row_master.sv
// Single-port BRAM row master: serialises writes, credited reads and a full-memory clear.
module mem_row_master
   import life_mem_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = '1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                inflight_q, inflight_d;
   logic                credit_ok, rd_fire;
   logic                fifo_in_ready;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [ADDR_W+DATA_W-1:0] fifo_out;

   // A read may only issue if its response is guaranteed a FIFO slot.
   assign credit_ok = fifo_in_ready && ((32'(fifo_cnt) + 32'(inflight_q)) < RSP_DEPTH);
   assign rd_fire   = rd_valid && rd_ready;
   assign inflight_d = rd_fire;
   assign rd_addr_d  = rd_fire ? rd_addr : rd_addr_q;

   // NOTE: every combinational output gets a default first so no path leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      clr_busy   = 1'b0;
      clr_done   = 1'b0;
      wr_ready   = 1'b0;
      rd_ready   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = mem_addr_q;
      mem_din    = '0;
      mem_addr_d = mem_addr_q;
      case (state_q)
         ST_IDLE: begin
            wr_ready = !clr_start;
            rd_ready = !clr_start && !wr_valid && credit_ok;
            if (clr_start) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end else if (wr_valid) begin
               mem_we   = 1'b1;
               mem_addr = wr_addr;
               mem_din  = wr_data;
            end else if (rd_valid && credit_ok) begin
               mem_addr = rd_addr;
            end
            mem_addr_d = mem_addr;
         end
         ST_CLEAR: begin
            clr_busy   = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = clr_cnt_q;
            clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
            mem_addr_d = clr_cnt_d;
            if (clr_cnt_q == LAST_ROW) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            clr_busy = 1'b1;
            if (!inflight_q) begin
               state_d  = ST_IDLE;
               clr_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         clr_cnt_q  <= '0;
         mem_addr_q <= '0;
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         mem_addr_q <= mem_addr_d;
         rd_addr_q  <= rd_addr_d;
         inflight_q <= inflight_d;
      end
   end

   rsp_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clka        (clka),
      .rst_n       (rst_n),
      .in_valid_i  (inflight_q),
      .in_ready_o  (fifo_in_ready),
      .in_data_i   ({rd_addr_q, mem_dout}),
      .out_valid_o (rsp_valid),
      .out_ready_i (rsp_ready),
      .out_data_o  (fifo_out),
      .count_o     (fifo_cnt)
   );

   assign rsp_addr = fifo_out[DATA_W +: ADDR_W];
   assign rsp_data = fifo_out[DATA_W-1:0];

endmodule

// File: doc/mem_row_master.md
MEM_ROW_MASTER -- requirements
Module: mem_row_master

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM row address width (1024 rows).
REQ-002 Parameter DATA_W, default 128, BRAM row width in cells.
REQ-003 Parameter RSP_DEPTH, default 2, read-response buffer entries.
REQ-004 clka  in  1  single clock; all logic rising-edge on clka.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 wr_valid / wr_ready  in / out  1 / 1  write request handshake.
REQ-007 wr_addr / wr_data  in / in  ADDR_W / DATA_W  write row address and row data.
REQ-008 rd_valid / rd_ready  in / out  1 / 1  read request handshake.
REQ-009 rd_addr  in  ADDR_W  read row address.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  read response handshake.
REQ-011 rsp_data / rsp_addr  out / out  DATA_W / ADDR_W  returned row and its address.
REQ-012 clr_start  in  1  one-cycle pulse; zero the whole memory.
REQ-013 clr_busy / clr_done  out / out  1 / 1  clear in progress; one-cycle completion pulse.
REQ-014 mem_we / mem_addr / mem_din  out  1 / ADDR_W / DATA_W  single-port BRAM drive.
REQ-015 mem_dout  in  DATA_W  BRAM read data, valid exactly 1 cycle after mem_addr with mem_we=0.

Function
REQ-016 FSM states: IDLE, CLEAR, DRAIN; transfer occurs when valid and ready are both high on a clka edge.
REQ-017 IDLE->CLEAR on clr_start; CLEAR->DRAIN after address 2^ADDR_W-1 is written; DRAIN->IDLE once no BRAM read is in flight.
REQ-018 In CLEAR: mem_we=1, mem_din=0, mem_addr counts 0..2^ADDR_W-1, one row per cycle, wrapping to 0 on exit; clr_busy=1.
REQ-019 clr_done pulses 1 cycle on the DRAIN->IDLE transition; 1024-row clear completes in 1024 cycles plus at most 1 cycle of drain.
REQ-020 clr_start while clr_busy=1 is ignored; wr_ready and rd_ready are 0 outside IDLE.
REQ-021 Priority in IDLE: clr_start > write > read; at most one BRAM access per cycle.
REQ-022 wr_ready = IDLE and not clr_start; an accepted write drives mem_we=1, mem_addr=wr_addr, mem_din=wr_data in the same cycle (combinational issue).
REQ-023 rd_ready = IDLE and not clr_start and not wr_valid and (buffered + in-flight) < RSP_DEPTH.
REQ-024 Accepted read drives mem_we=0, mem_addr=rd_addr; the next cycle mem_dout and the captured address enter the response FIFO.
REQ-025 Read-to-rsp_valid latency: 2 cycles when the FIFO is empty; responses are returned strictly in request order.
REQ-026 Response FIFO: RSP_DEPTH entries; simultaneous push and pop keeps the count unchanged; no overflow is possible due to REQ-023 credit.
REQ-027 rsp_data and rsp_addr are held stable while rsp_valid=1 and rsp_ready=0.
REQ-028 Write followed by read to the same address returns the written data (single-port write-first is not required; ordering is guaranteed by serial issue).
REQ-029 Idle outputs: mem_we=0, mem_addr holds its last value, mem_din=0.

Reset
REQ-030 rst_n low asynchronously forces: state=IDLE, clear counter=0, FIFO empty, in-flight flag=0, rsp_valid=0, clr_busy=0, clr_done=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-031 Reset during CLEAR aborts the clear with no clr_done pulse; partially cleared rows are left as they are.
REQ-032 Reset with a read in flight discards its data; no response appears after rst_n deasserts.

Structure
REQ-033 ADDR_W, DATA_W, RSP_DEPTH defaults and state encoding live in the shared life_mem_pkg package.
REQ-034 The response FIFO is one sub-module, rsp_fifo (parameterised width/depth, valid/ready both sides).
REQ-035 The BRAM wrapper is instantiated outside this block; mem_* ports connect 1:1 to its wea/addra/dina/douta.

Verification
REQ-036 Write addr 5 data 128'hA5..A5, then read addr 5 -> rsp_valid 2 cycles after read accept, rsp_data=A5..A5, rsp_addr=5.
REQ-037 Back-to-back reads 0,1,2 with rsp_ready=0 -> rd_ready drops after 2 accepts; release rsp_ready -> responses 0,1,2 in order, none lost.
REQ-038 Same-cycle wr_valid and rd_valid -> write issued first, read accepted the following cycle.
REQ-039 clr_start after filling rows 0 and 1023 with ones -> clr_busy for 1024+ cycles, single clr_done pulse, reads of 0 and 1023 return 0.
REQ-040 rst_n low at clear row 300 -> no clr_done; after release, rows <300 read 0 and rows >=300 keep their old data.
REQ-041 rst_n low with one read in flight and one buffered -> rsp_valid=0 immediately; no response after release.
